// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ALLOC,
    REQ,
    WAIT,
    WRITE,
    FIN
  } state_t;

  localparam int unsigned TAM_BLOCO_DEF = 200;

  // Width of a slot index; never narrower than one bit.
  function automatic int unsigned slot_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// HD read handshake and instruction-memory write port used by the loader.
interface instr_mem_loader_if #(
  parameter int unsigned HD_AW = 16
) ();

  logic             hd_rd_en;
  logic [HD_AW-1:0] hd_addr;
  logic [31:0]      hd_data;
  logic             hd_valid;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;

  modport master (
    output hd_rd_en, hd_addr, mem_we, mem_addr, mem_wdata,
    input  hd_data, hd_valid
  );

  modport slave (
    input  hd_rd_en, hd_addr, mem_we, mem_addr, mem_wdata,
    output hd_data, hd_valid
  );

endinterface

// File: rtl/instr_mem_loader_slot_allocator.sv
// Process-slot bitmap: lowest-free priority encoder, full flag, set/release.
module slot_allocator
  import loader_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         alloc,
  input  logic                         rel_a,
  input  logic [slot_w(NUM_SLOTS)-1:0] rel_a_slot,
  input  logic                         rel_b,
  input  logic [slot_w(NUM_SLOTS)-1:0] rel_b_slot,
  output logic [NUM_SLOTS-1:0]         bitmap,
  output logic                         full,
  output logic [slot_w(NUM_SLOTS)-1:0] free_idx
);

  localparam int unsigned SW = slot_w(NUM_SLOTS);

  logic [NUM_SLOTS-1:0] held;
  logic [NUM_SLOTS-1:0] set_mask;

  // Releases are applied before the free search so a slot freed this cycle can be reused.
  always_comb begin
    held = bitmap;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if ((rel_a && rel_a_slot == SW'(i)) || (rel_b && rel_b_slot == SW'(i)))
        held[i] = 1'b0;
    end
    full     = &held;
    free_idx = '0;
    for (int unsigned i = NUM_SLOTS; i > 0; i--) begin
      if (!held[i-1]) free_idx = SW'(i-1);
    end
    set_mask = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (alloc && !full && free_idx == SW'(i)) set_mask[i] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) bitmap <= '0;
    else        bitmap <= held | set_mask;
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Copies a program image from HD into a free instruction-memory slot.
// Optional WAIT watchdog enabled by defining LOADER_TIMEOUT_EN.
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int unsigned TAM_BLOCO = TAM_BLOCO_DEF,
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned HD_AW     = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [HD_AW-1:0]             hd_base,
  input  logic [31:0]                  prog_len,
  input  logic                         release_req,
  input  logic [slot_w(NUM_SLOTS)-1:0] release_slot,
  instr_mem_loader_if.master           bus,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [slot_w(NUM_SLOTS)-1:0] slot_id,
  output logic [31:0]                  slot_base,
  output logic [NUM_SLOTS-1:0]         slots_used
);

  localparam int unsigned SW = slot_w(NUM_SLOTS);

  state_t           state;
  logic [HD_AW-1:0] base_r;
  logic [31:0]      len_r;
  logic [31:0]      cnt;
  logic             full;
  logic [SW-1:0]    free_idx;
  logic             alloc_ok;
  logic             rel_hit;
  logic             wd_abort;

  assign busy     = (state != IDLE);
  assign alloc_ok = (state == ALLOC) && (len_r != '0) && (len_r <= 32'(TAM_BLOCO)) && !full;
  assign rel_hit  = release_req && (release_slot == slot_id) && (state inside {REQ, WAIT, WRITE});

`ifdef LOADER_TIMEOUT_EN
  logic [15:0] wd;
  // wd holds the index of the current WAIT cycle, so the abort fires on cycle 65535.
  assign wd_abort = (state == WAIT) && !bus.hd_valid && (wd == 16'hFFFF);
`else
  assign wd_abort = 1'b0;
`endif

  slot_allocator #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_alloc (
    .clock      (clock),
    .reset      (reset),
    .alloc      (alloc_ok),
    .rel_a      (release_req),
    .rel_a_slot (release_slot),
    .rel_b      (wd_abort),
    .rel_b_slot (slot_id),
    .bitmap     (slots_used),
    .full       (full),
    .free_idx   (free_idx)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      base_r        <= '0;
      len_r         <= '0;
      cnt           <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
      slot_id       <= '0;
      slot_base     <= '0;
      bus.hd_rd_en  <= 1'b0;
      bus.hd_addr   <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
`ifdef LOADER_TIMEOUT_EN
      wd            <= '0;
`endif
    end else begin
      bus.hd_rd_en <= 1'b0;
      bus.mem_we   <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      // An abort pre-empts whatever the active state would do this cycle.
      if (rel_hit || wd_abort) begin
        error <= 1'b1;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              base_r <= hd_base;
              len_r  <= prog_len;
              state  <= ALLOC;
            end
          end
          ALLOC: begin
            if (alloc_ok) begin
              slot_id      <= free_idx;
              slot_base    <= 32'(free_idx) * 32'(TAM_BLOCO);
              cnt          <= '0;
              bus.hd_rd_en <= 1'b1;
              bus.hd_addr  <= base_r;
              state        <= REQ;
            end else begin
              error <= 1'b1;
              state <= IDLE;
            end
          end
          REQ: begin
`ifdef LOADER_TIMEOUT_EN
            wd    <= 16'd1;
`endif
            state <= WAIT;
          end
          WAIT: begin
            if (bus.hd_valid) begin
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= slot_base + cnt;
              bus.mem_wdata <= bus.hd_data;
              state         <= WRITE;
            end
`ifdef LOADER_TIMEOUT_EN
            else begin
              wd <= wd + 16'd1;
            end
`endif
          end
          WRITE: begin
            cnt <= cnt + 32'd1;
            if (cnt + 32'd1 == len_r) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              bus.hd_rd_en <= 1'b1;
              bus.hd_addr  <= base_r + HD_AW'(cnt + 32'd1);
              state        <= REQ;
            end
          end
          FIN:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader with a randomized HD responder and slot model.
module tb_instr_mem_loader;

  localparam int unsigned TAMB = 200;
  localparam int unsigned NS   = 4;
  localparam int unsigned AW   = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] hd_base = '0;
  logic [31:0]   prog_len = '0;
  logic          release_req = 1'b0;
  logic [1:0]    release_slot = '0;
  logic          busy, done, error;
  logic [1:0]    slot_id;
  logic [31:0]   slot_base;
  logic [NS-1:0] slots_used;

  instr_mem_loader_if #(.HD_AW(AW)) bus ();

  instr_mem_loader #(
    .TAM_BLOCO (TAMB),
    .NUM_SLOTS (NS),
    .HD_AW     (AW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .hd_base      (hd_base),
    .prog_len     (prog_len),
    .release_req  (release_req),
    .release_slot (release_slot),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .slot_id      (slot_id),
    .slot_base    (slot_base),
    .slots_used   (slots_used)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] seed;
  logic [NS-1:0] m_bitmap = '0;
  bit          hd_hold = 1'b0;
  int unsigned lat_min = 1, lat_max = 1;
  int unsigned extra_wait = 0;

  typedef struct packed {logic [31:0] a; logic [31:0] d;} wr_t;
  wr_t           wq[$];
  logic [AW-1:0] rq[$];
  int            done_n = 0, err_n = 0;

  function automatic logic [31:0] hd_word(input logic [AW-1:0] a);
    return {a, ~a} ^ seed;
  endfunction

  function automatic int lowest_free(input logic [NS-1:0] bm);
    for (int i = 0; i < int'(NS); i++) if (!bm[i]) return i;
    return -1;
  endfunction

  // HD model: answers each strobe after d cycles with the word stored at that address.
  initial begin
    logic [AW-1:0] a;
    int unsigned   d;
    bus.hd_valid = 1'b0;
    bus.hd_data  = '0;
    forever begin
      @(negedge clock);
      if (bus.hd_rd_en === 1'b1 && !hd_hold) begin
        a = bus.hd_addr;
        d = $urandom_range(lat_max, lat_min);
        extra_wait += d - 1;
        repeat (d) @(negedge clock);
        bus.hd_data  = hd_word(a);
        bus.hd_valid = 1'b1;
        @(negedge clock);
        bus.hd_valid = 1'b0;
        bus.hd_data  = '0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (bus.mem_we === 1'b1) wq.push_back({bus.mem_addr, bus.mem_wdata});
      if (bus.hd_rd_en === 1'b1) rq.push_back(bus.hd_addr);
      if (done === 1'b1) done_n++;
      if (error === 1'b1) err_n++;
    end
  end

  task automatic clear_obs();
    wq.delete();
    rq.delete();
    done_n = 0;
    err_n = 0;
    extra_wait = 0;
  endtask

  task automatic do_load(input logic [AW-1:0] base, input int unsigned len, input int unsigned budget,
                         output int unsigned bcyc, output bit to);
    clear_obs();
    @(negedge clock);
    hd_base  = base;
    prog_len = len;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    bcyc  = 0;
    while (busy && bcyc < budget) begin
      bcyc++;
      @(negedge clock);
    end
    to = busy;
    repeat (2) @(negedge clock);
  endtask

  task automatic pulse_release(input int unsigned s);
    @(negedge clock);
    release_req  = 1'b1;
    release_slot = 2'(s);
    @(negedge clock);
    release_req = 1'b0;
    m_bitmap[s] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({busy, done, error, bus.hd_rd_en, bus.mem_we} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000", {busy, done, error, bus.hd_rd_en, bus.mem_we});
    end
    checks++;
    if ({slot_id, slot_base, slots_used} !== '0) begin
      errors++; $display("FAIL reset_slot got id=%0d base=%0d used=%b want 0", slot_id, slot_base, slots_used);
    end
    checks++;
    if ({bus.hd_addr, bus.mem_addr, bus.mem_wdata} !== '0) begin
      errors++; $display("FAIL reset_bus got hd=%h ma=%h md=%h want 0", bus.hd_addr, bus.mem_addr, bus.mem_wdata);
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic();
    int unsigned bc; bit to; int mism;
    lat_min = 2; lat_max = 2;
    do_load(16'h0040, 3, 200, bc, to);
    checks++;
    if (to || done_n != 1 || err_n != 0) begin
      errors++; $display("FAIL basic_outcome got to=%0d done=%0d err=%0d want 0 1 0", to, done_n, err_n);
    end
    mism = (rq.size() != 3) ? 1 : 0;
    if (mism == 0) for (int i = 0; i < 3; i++) if (rq[i] !== AW'(16'h0040 + i)) mism++;
    checks++;
    if (mism != 0) begin
      errors++; $display("FAIL basic_hd_addr got %0d reads (%0d bad) want 0x40..0x42", rq.size(), mism);
    end
    mism = (wq.size() != 3) ? 1 : 0;
    if (mism == 0) for (int i = 0; i < 3; i++)
      if (wq[i].a !== 32'(i) || wq[i].d !== hd_word(AW'(16'h0040 + i))) mism++;
    checks++;
    if (mism != 0) begin
      errors++; $display("FAIL basic_writes got %0d writes (%0d bad) want 3 at 0..2", wq.size(), mism);
    end
    checks++;
    if (slot_id !== 2'd0 || slots_used !== 4'b0001) begin
      errors++; $display("FAIL basic_slot got id=%0d used=%b want 0 0001", slot_id, slots_used);
    end
    checks++;
    if (bc != 14) begin
      errors++; $display("FAIL basic_latency got %0d want 14", bc);
    end
    m_bitmap = 4'b0001;
  endtask

  task automatic test_alloc();
    int unsigned bc; bit to; logic [AW-1:0] b;
    lat_min = 1; lat_max = 3;
    for (int k = 1; k < 4; k++) begin
      b = AW'($urandom);
      do_load(b, 1, 100, bc, to);
      checks++;
      if (to || done_n != 1 || slot_base !== 32'(k * 200) || wq.size() != 1) begin
        errors++; $display("FAIL alloc_load%0d got done=%0d base=%0d writes=%0d want 1 %0d 1", k, done_n, slot_base, wq.size(), k * 200);
      end else begin
        checks++;
        if (wq[0] !== {32'(k * 200), hd_word(b)}) begin
          errors++; $display("FAIL alloc_word%0d got %h want %h", k, wq[0], {32'(k * 200), hd_word(b)});
        end
      end
    end
    m_bitmap = 4'b1111;
    do_load(AW'($urandom), 1, 100, bc, to);
    checks++;
    if (err_n != 1 || done_n != 0 || wq.size() != 0 || rq.size() != 0 || bc != 1) begin
      errors++; $display("FAIL alloc_full got err=%0d done=%0d wr=%0d rd=%0d cyc=%0d want 1 0 0 0 1", err_n, done_n, wq.size(), rq.size(), bc);
    end
    checks++;
    if (slots_used !== 4'b1111) begin
      errors++; $display("FAIL alloc_bitmap got %b want 1111", slots_used);
    end
  endtask

  task automatic test_release_reuse();
    int unsigned bc; bit to; int unsigned len; logic [AW-1:0] b; int mism;
    pulse_release(1);
    checks++;
    if (slots_used !== 4'b1101) begin
      errors++; $display("FAIL release_bit got %b want 1101", slots_used);
    end
    len = $urandom_range(8, 1);
    b = AW'($urandom);
    do_load(b, len, 300, bc, to);
    mism = (wq.size() != len) ? 1 : 0;
    if (mism == 0) for (int i = 0; i < int'(len); i++)
      if (wq[i] !== {32'(200 + i), hd_word(AW'(b + i))}) mism++;
    checks++;
    if (to || slot_id !== 2'd1 || slot_base !== 32'd200 || slots_used !== 4'b1111 || mism != 0) begin
      errors++; $display("FAIL reuse got id=%0d base=%0d used=%b bad=%0d want 1 200 1111 0", slot_id, slot_base, slots_used, mism);
    end
    m_bitmap = 4'b1111;
  endtask

  task automatic test_bounds();
    int unsigned bc; bit to; logic [AW-1:0] b; int mism;
    pulse_release(2);
    pulse_release(3);
    pulse_release(3);
    checks++;
    if (slots_used !== 4'b0011) begin
      errors++; $display("FAIL bounds_noop_release got %b want 0011", slots_used);
    end
    do_load(16'h0100, 0, 100, bc, to);
    checks++;
    if (err_n != 1 || done_n != 0 || rq.size() != 0 || bc != 1) begin
      errors++; $display("FAIL bounds_len0 got err=%0d rd=%0d cyc=%0d want 1 0 1", err_n, rq.size(), bc);
    end
    do_load(16'h0100, 201, 100, bc, to);
    checks++;
    if (err_n != 1 || done_n != 0 || rq.size() != 0 || slots_used !== 4'b0011) begin
      errors++; $display("FAIL bounds_len201 got err=%0d rd=%0d used=%b want 1 0 0011", err_n, rq.size(), slots_used);
    end
    b = AW'($urandom);
    do_load(b, 200, 2000, bc, to);
    mism = (wq.size() != 200) ? 1 : 0;
    if (mism == 0) for (int i = 0; i < 200; i++)
      if (wq[i] !== {32'(400 + i), hd_word(AW'(b + i))}) mism++;
    checks++;
    if (to || done_n != 1 || mism != 0) begin
      errors++; $display("FAIL bounds_len200 got done=%0d writes=%0d bad=%0d want 1 200 0", done_n, wq.size(), mism);
    end
    checks++;
    if (wq.size() == 0 || wq[wq.size()-1].a !== 32'd599) begin
      errors++; $display("FAIL bounds_last_addr got %0d writes want last at 599", wq.size());
    end
    checks++;
    if (bc != 2 + 600 + extra_wait) begin
      errors++; $display("FAIL bounds_latency got %0d want %0d", bc, 2 + 600 + extra_wait);
    end
    m_bitmap = 4'b0111;
  endtask

  task automatic test_random();
    int unsigned bc; bit to; int unsigned len, r; logic [AW-1:0] b; int es, mism; bit ok;
    for (int s = 0; s < int'(NS); s++) pulse_release(s);
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(1, 0) == 0) pulse_release($urandom_range(NS - 1, 0));
      r = $urandom_range(9, 0);
      len = (r == 0) ? 0 : (r == 1) ? $urandom_range(300, 201) : (r == 2) ? 200 : $urandom_range(12, 1);
      b = (k == 0) ? 16'hFFFE : AW'($urandom);
      if (k == 0) len = 5;
      es = lowest_free(m_bitmap);
      ok = (len >= 1) && (len <= 200) && (es >= 0);
      do_load(b, len, 2000, bc, to);
      if (ok) m_bitmap[es] = 1'b1;
      checks++;
      if (to || done_n != (ok ? 1 : 0) || err_n != (ok ? 0 : 1)) begin
        errors++; $display("FAIL rand%0d_outcome got done=%0d err=%0d to=%0d want ok=%0d", k, done_n, err_n, to, ok);
      end
      mism = (wq.size() != (ok ? len : 0) || rq.size() != (ok ? len : 0)) ? 1 : 0;
      if (ok && mism == 0) for (int i = 0; i < int'(len); i++)
        if (rq[i] !== AW'(b + i) || wq[i] !== {32'(es * 200 + i), hd_word(AW'(b + i))}) mism++;
      checks++;
      if (mism != 0) begin
        errors++; $display("FAIL rand%0d_data got wr=%0d rd=%0d bad=%0d want len=%0d", k, wq.size(), rq.size(), mism, ok ? len : 0);
      end
      checks++;
      if (slots_used !== m_bitmap || (ok && slot_id !== 2'(es))) begin
        errors++; $display("FAIL rand%0d_slot got used=%b id=%0d want %b %0d", k, slots_used, slot_id, m_bitmap, es);
      end
      checks++;
      if (bc != (ok ? 2 + 3 * len + extra_wait : 1)) begin
        errors++; $display("FAIL rand%0d_latency got %0d want %0d", k, bc, ok ? 2 + 3 * len + extra_wait : 1);
      end
    end
  endtask

  task automatic test_abort();
    int n;
    for (int s = 0; s < int'(NS); s++) pulse_release(s);
    lat_min = 1; lat_max = 2;
    clear_obs();
    @(negedge clock);
    hd_base = 16'h0200; prog_len = 6; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (wq.size() < 2 && n < 200) begin n++; @(negedge clock); end
    pulse_release(0);
    n = 0;
    while (busy && n < 20) begin n++; @(negedge clock); end
    repeat (10) @(negedge clock);
    checks++;
    if (err_n != 1 || done_n != 0 || wq.size() != 2) begin
      errors++; $display("FAIL abort_release got err=%0d done=%0d writes=%0d want 1 0 2", err_n, done_n, wq.size());
    end
    checks++;
    if (slots_used !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_state got used=%b busy=%b want 0000 0", slots_used, busy);
    end
    hd_hold = 1'b1;
    clear_obs();
    @(negedge clock);
    prog_len = 4; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (rq.size() < 1 && n < 20) begin n++; @(negedge clock); end
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL abort_pre_reset got busy=%b want 1", busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, error, bus.hd_rd_en, bus.mem_we} !== 5'b0 || {slot_id, slot_base, slots_used} !== '0) begin
      errors++; $display("FAIL abort_async_reset got ctrl=%b id=%0d base=%0d used=%b want 0", {busy, done, error, bus.hd_rd_en, bus.mem_we}, slot_id, slot_base, slots_used);
    end
    @(negedge clock);
    reset = 1'b1;
    hd_hold = 1'b0;
    m_bitmap = '0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_timeout();
    int unsigned bc; bit to;
    hd_hold = 1'b1;
    do_load(16'h1234, 2, 70000, bc, to);
`ifdef LOADER_TIMEOUT_EN
    checks++;
    if (to || bc != 65537 || err_n != 1 || done_n != 0) begin
      errors++; $display("FAIL timeout_abort got to=%0d cyc=%0d err=%0d want 0 65537 1", to, bc, err_n);
    end
    checks++;
    if (slots_used !== 4'b0000) begin
      errors++; $display("FAIL timeout_slot got %b want 0000", slots_used);
    end
`else
    checks++;
    if (!to || busy !== 1'b1 || err_n != 0) begin
      errors++; $display("FAIL timeout_hold got busy=%b err=%0d want 1 0", busy, err_n);
    end
    pulse_release(0);
    repeat (3) @(negedge clock);
    checks++;
    if (err_n != 1 || busy !== 1'b0 || slots_used !== 4'b0000) begin
      errors++; $display("FAIL timeout_release got err=%0d busy=%b used=%b want 1 0 0000", err_n, busy, slots_used);
    end
`endif
    hd_hold = 1'b0;
  endtask

  initial begin
    seed = $urandom;
    test_reset();
    test_basic();
    test_alloc();
    test_release_reuse();
    test_bounds();
    test_random();
    test_abort();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
